// File: rtl/std_setbit_scanner.sv
// rtl/std_setbit_scanner.sv - sequential set-bit enumerator, one set-bit index per beat, LSB first
//
// Accepts a W-bit vector over a valid/ready handshake, then emits one beat per
// set bit carrying the bit position and a running 1-based ordinal. An all-zero
// vector yields a single beat flagged empty.
//
// Ports:
//   i_clk    - clock, all state updates on the rising edge
//   i_rst_n  - synchronous active-low reset
//   i_valid  - input vector valid
//   o_ready  - block can accept a vector (idle and out of reset)
//   i_data   - vector to scan
//   o_valid  - output beat valid
//   i_ready  - downstream accepts the beat
//   o_index  - bit position of the current set bit
//   o_count  - 1-based ordinal of the current beat, 0 on an empty beat
//   o_last   - final beat of the current vector
//   o_empty  - input vector was all zeros

module std_setbit_scanner #(
    parameter  int W    = 16,
    localparam int IDXW = (W > 1) ? $clog2(W) : 1,
    localparam int CW   = (W > 1) ? $clog2(W) + 1 : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [W-1:0]    i_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [IDXW-1:0] o_index,
    output logic [CW-1:0]   o_count,
    output logic            o_last,
    output logic            o_empty
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    work;     // bits still to be reported
    logic [CW-1:0]   ordinal;  // beats already accepted for this vector
    logic            empty;

    logic [IDXW-1:0] low_idx;
    logic [W-1:0]    work_next;
    logic            beat_last;

    // Clearing the lowest set bit both advances the scan and tells us whether
    // more than one bit remains (nonzero result means another beat follows).
    assign work_next = work & (work - W'(1));
    assign beat_last = (work_next == '0);

    // Lowest set bit wins: scan from the top so lower positions overwrite.
    always_comb begin
        low_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (work[i]) begin
                low_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            work    <= '0;
            ordinal <= '0;
            empty   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        work    <= i_data;
                        ordinal <= '0;
                        empty   <= (i_data == '0);
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (i_ready) begin
                        work    <= work_next;
                        ordinal <= ordinal + CW'(1);
                        if (beat_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is a pure function of registers, so it is stable across stalls
    // and has no path from i_valid/i_data. o_ready is gated by reset so no
    // vector is offered acceptance while reset is held.
    assign o_ready = i_rst_n && (state == IDLE);
    assign o_valid = (state == SCAN);
    assign o_index = low_idx;
    assign o_count = empty ? '0 : (ordinal + CW'(1));
    assign o_last  = beat_last;
    assign o_empty = empty;

endmodule
